// File: rtl/vmem_arb_pkg.sv
// Shared types and defaults for the video-memory arbiter.
// The stats feature is enabled by defining VMEM_ARB_STATS_EN.
package vmem_arb_pkg;

  localparam int AW_DEF = 19;
  localparam int DW_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/vmem_wr_fifo.sv
// Write buffer for the video-memory arbiter.
// Power-of-2 depth, wrapping pointers, synchronous flush.
module vmem_wr_fifo
  import vmem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = AW_DEF + DW_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [PW:0]  level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   lvl_q, lvl_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      lvl_d = lvl_q + {{PW{1'b0}}, push_i}
                    - {{PW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (lvl_q == (PW+1)'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;

endmodule

// File: rtl/vmem_arb.sv
// Video-memory arbiter: scanout reads beat buffered writes.
// Optional counters via VMEM_ARB_STATS_EN.
module vmem_arb
  import vmem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  output logic          vga_rvalid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef VMEM_ARB_STATS_EN
  output logic [15:0]   wr_done_cnt,
  output logic [15:0]   stall_cnt,
`endif
  output logic [LW-1:0] fifo_level,
  output logic [1:0]    state
);

  state_e        state_q, state_d;
  logic          rdy_q;
  logic          rv_q;
  logic [DW-1:0] hold_q;
  logic          full, empty;
  logic          scan_g, wr_g, push;
  logic [AW+DW-1:0] head;

  vmem_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (wr_g),
    .din_i   ({wr_addr, wr_data}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  // rdy_q keeps the writer stalled until the first edge out of reset
  assign wr_ready = rdy_q & ~full & ~flush;
  assign push     = wr_valid & wr_ready;
  assign scan_g   = resetn & vga_req;
  assign wr_g     = resetn & ~vga_req & ~empty & ~flush;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    state_d   = IDLE;
    unique case (1'b1)
      scan_g: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
        state_d  = SCAN;
      end
      wr_g: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head[AW+DW-1:DW];
        mem_wdata = head[DW-1:0];
        state_d   = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      rv_q    <= scan_g;
      hold_q  <= vga_data;
    end
  end

  assign vga_rvalid = rv_q;
  assign vga_data   = rv_q ? mem_rdata : hold_q;
  assign state      = state_q;

`ifdef VMEM_ARB_STATS_EN
  logic [15:0] wd_q, wd_d;
  logic [15:0] st_q, st_d;

  always_comb begin
    wd_d = wd_q;
    st_d = st_q;
    if (flush) begin
      wd_d = '0;
      st_d = '0;
    end else begin
      if (wr_g && wd_q != 16'hFFFF) wd_d = wd_q + 16'd1;
      if (wr_valid && !wr_ready && st_q != 16'hFFFF)
        st_d = st_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
      st_q <= '0;
    end else begin
      wd_q <= wd_d;
      st_q <= st_d;
    end
  end

  assign wr_done_cnt = wd_q;
  assign stall_cnt   = st_q;
`endif

endmodule
